// File: rtl/reset_sequencer.sv
// Ordered reset release: holds every stage in reset, then releases them one at a
// time, waiting for each stage's ready acknowledge plus a guard gap; ack timeouts retry.
module reset_sequencer #(
    parameter int unsigned STAGES         = 4,
    parameter logic [31:0] HOLD_CYCLES    = 32'd1000,
    parameter logic [31:0] GAP_CYCLES     = 32'd100,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd500000,
    parameter int unsigned RETRY_MAX      = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sw_rst_req,
    input  logic [STAGES-1:0] stage_ready,
    output logic [STAGES-1:0] rst_stage_o,
    output logic              all_released_o,
    output logic              busy_o,
    output logic              timeout_o,
    output logic              fault_lock_o
);

    localparam int unsigned       KW       = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam int unsigned       RW       = $clog2(RETRY_MAX + 1) + 1;
    localparam logic [KW-1:0]     K_LAST   = KW'(STAGES - 1);
    localparam logic [RW-1:0]     R_MAX    = RW'(RETRY_MAX);
    localparam logic [STAGES-1:0] ALL_ONES = {STAGES{1'b1}};

    typedef enum logic [2:0] {
        S_HOLD,
        S_RELEASE,
        S_WAIT_RDY,
        S_GAP,
        S_DONE,
        S_FAULT,
        S_FAULT_LOCK
    } state_t;

    state_t            r_state;
    logic [31:0]       r_cnt;
    logic [KW-1:0]     r_k;
    logic [RW-1:0]     r_retry;
    logic [STAGES-1:0] r_stage;
    logic              r_all;
    logic              r_busy;
    logic              r_timeout;
    logic              r_fault_lock;

    // Sequencer FSM; rst beats sw_rst_req, which beats every state transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_HOLD;
            r_cnt        <= 32'd0;
            r_k          <= '0;
            r_retry      <= '0;
            r_stage      <= ALL_ONES;
            r_all        <= 1'b0;
            r_busy       <= 1'b1;
            r_timeout    <= 1'b0;
            r_fault_lock <= 1'b0;
        end else if (sw_rst_req) begin
            r_state      <= S_HOLD;
            r_cnt        <= 32'd0;
            r_k          <= '0;
            r_retry      <= '0;
            r_stage      <= ALL_ONES;
            r_all        <= 1'b0;
            r_busy       <= 1'b1;
            r_fault_lock <= 1'b0;
        end else begin
            case (r_state)
                S_HOLD: begin
                    if (r_cnt == HOLD_CYCLES - 32'd1) begin
                        r_state <= S_RELEASE;
                        r_cnt   <= 32'd0;
                        r_k     <= '0;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                S_RELEASE: begin
                    r_stage[r_k] <= 1'b0;
                    r_state      <= S_WAIT_RDY;
                    r_cnt        <= 32'd0;
                end
                S_WAIT_RDY: begin
                    // A ready seen on the last allowed cycle still counts as success.
                    if (stage_ready[r_k]) begin
                        r_state <= S_GAP;
                        r_cnt   <= 32'd0;
                    end else if (r_cnt == TIMEOUT_CYCLES - 32'd1) begin
                        r_state <= S_FAULT;
                        r_cnt   <= 32'd0;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                S_GAP: begin
                    if (r_cnt == GAP_CYCLES - 32'd1) begin
                        r_cnt <= 32'd0;
                        if (r_k == K_LAST) begin
                            r_state <= S_DONE;
                            r_all   <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_k     <= r_k + 1'b1;
                            r_state <= S_RELEASE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_DONE;
                end
                S_FAULT: begin
                    r_timeout <= 1'b1;
                    r_stage   <= ALL_ONES;
                    r_cnt     <= 32'd0;
                    r_k       <= '0;
                    if (r_retry < R_MAX) begin
                        r_retry <= r_retry + 1'b1;
                        r_state <= S_HOLD;
                    end else begin
                        r_state      <= S_FAULT_LOCK;
                        r_fault_lock <= 1'b1;
                        r_busy       <= 1'b0;
                    end
                end
                S_FAULT_LOCK: begin
                    r_stage <= ALL_ONES;
                end
                default: begin
                    r_state <= S_HOLD;
                    r_cnt   <= 32'd0;
                    r_k     <= '0;
                    r_stage <= ALL_ONES;
                    r_all   <= 1'b0;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    assign rst_stage_o    = r_stage;
    assign all_released_o = r_all;
    assign busy_o         = r_busy;
    assign timeout_o      = r_timeout;
    assign fault_lock_o   = r_fault_lock;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: per-scenario release timelines derived from stage delays
// and compared cycle by cycle against the DUT outputs.
module tb_reset_sequencer;

    localparam int HOLD = 10;
    localparam int GAP  = 3;
    localparam int TMO  = 20;
    localparam int RMAX = 1;
    localparam int MAXT = 300;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sw_rst_req = 1'b0;
    logic [3:0] stage_ready = 4'h0;
    logic [3:0] rst_stage_o;
    logic       all_released_o;
    logic       busy_o;
    logic       timeout_o;
    logic       fault_lock_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Per-scenario model timeline, index = cycles after the reset/sw edge.
    logic [3:0] exp_stage [MAXT];
    logic [3:0] rdy       [MAXT];
    logic       exp_all   [MAXT];
    logic       exp_busy  [MAXT];
    logic       exp_to    [MAXT];
    logic       exp_fl    [MAXT];
    int         dly [4];
    int         scen_end;
    logic       last_to = 1'b0;
    int         obs_drop [4];
    int         obs_done;

    reset_sequencer #(
        .STAGES(4),
        .HOLD_CYCLES(32'd10),
        .GAP_CYCLES(32'd3),
        .TIMEOUT_CYCLES(32'd20),
        .RETRY_MAX(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sw_rst_req(sw_rst_req),
        .stage_ready(stage_ready),
        .rst_stage_o(rst_stage_o),
        .all_released_o(all_released_o),
        .busy_o(busy_o),
        .timeout_o(timeout_o),
        .fault_lock_o(fault_lock_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Stage k drops HOLD+1 after start (k=0) or GAP+1 after the previous ready is
    // sampled; ready set d cycles after the drop is sampled one cycle later.
    // A stage whose ready never comes within TMO causes all-ones TMO+1 after its drop.
    task automatic build(input logic to_in);
        int t_start, ex, fo, retry, done_t, lock_t, first_fo, endt;
        int drop [4];
        int nk;
        bit faulted, finished;
        for (int t = 0; t < MAXT; t++) begin
            exp_stage[t] = 4'hF;
            rdy[t]       = 4'h0;
        end
        t_start = 0; retry = 0; done_t = -1; lock_t = -1; first_fo = -1;
        ex = 0; fo = 0; finished = 1'b0;
        while (!finished) begin
            faulted = 1'b0;
            nk = 0;
            for (int k = 0; k < 4 && !faulted; k++) begin
                drop[k] = (k == 0) ? t_start + HOLD + 1 : ex + GAP + 1;
                nk = k + 1;
                if (dly[k] < TMO) begin
                    ex = drop[k] + dly[k] + 1;
                end else begin
                    fo = drop[k] + TMO + 1;
                    faulted = 1'b1;
                end
            end
            endt = faulted ? fo : MAXT;
            for (int k = 0; k < nk; k++) begin
                for (int t = drop[k]; t < endt; t++) begin
                    exp_stage[t][k] = 1'b0;
                    if (dly[k] < TMO && t >= drop[k] + dly[k]) rdy[t][k] = 1'b1;
                end
            end
            if (faulted) begin
                if (first_fo < 0) first_fo = fo;
                if (retry < RMAX) begin
                    retry++;
                    t_start = fo;
                end else begin
                    lock_t = fo;
                    finished = 1'b1;
                end
            end else begin
                done_t = ex + GAP;
                finished = 1'b1;
            end
        end
        for (int t = 0; t < MAXT; t++) begin
            exp_all[t]  = (done_t >= 0 && t >= done_t);
            exp_fl[t]   = (lock_t >= 0 && t >= lock_t);
            exp_busy[t] = !(exp_all[t] || exp_fl[t]);
            exp_to[t]   = to_in || (first_fo >= 0 && t >= first_fo);
        end
        scen_end = ((done_t >= 0) ? done_t : lock_t) + 4;
    endtask

    task automatic check_at(input string name, input int t);
        chk($sformatf("%s[%0d] rst_stage_o", name, t), 32'(rst_stage_o), 32'(exp_stage[t]));
        chk($sformatf("%s[%0d] all_released_o", name, t), 32'(all_released_o), 32'(exp_all[t]));
        chk($sformatf("%s[%0d] busy_o", name, t), 32'(busy_o), 32'(exp_busy[t]));
        chk($sformatf("%s[%0d] timeout_o", name, t), 32'(timeout_o), 32'(exp_to[t]));
        chk($sformatf("%s[%0d] fault_lock_o", name, t), 32'(fault_lock_o), 32'(exp_fl[t]));
        last_to = exp_to[t];
        for (int k = 0; k < 4; k++)
            if (rst_stage_o[k] === 1'b0 && obs_drop[k] < 0) obs_drop[k] = t;
        if (all_released_o === 1'b1 && obs_done < 0) obs_done = t;
    endtask

    task automatic begin_scn(input string name, input bit use_sw);
        logic to_in;
        stage_ready = 4'h0;
        if (use_sw) begin
            to_in = last_to;
            sw_rst_req = 1'b1;
            @(posedge clk); #1;
            sw_rst_req = 1'b0;
        end else begin
            to_in = 1'b0;
            rst = 1'b1;
            @(posedge clk);
            @(posedge clk); #1;
            rst = 1'b0;
        end
        build(to_in);
        for (int k = 0; k < 4; k++) obs_drop[k] = -1;
        obs_done = -1;
        check_at(name, 0);
    endtask

    task automatic play(input string name, input int len);
        for (int t = 1; t <= len; t++) begin
            stage_ready = rdy[t-1];
            @(posedge clk); #1;
            check_at(name, t);
        end
    endtask

    task automatic set_dly(input int d0, input int d1, input int d2, input int d3);
        dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3;
    endtask

    task automatic chk_pitch(input string name);
        chk({name, " drop0"}, 32'(obs_drop[0]), 32'd11);
        chk({name, " drop1"}, 32'(obs_drop[1]), 32'd16);
        chk({name, " drop2"}, 32'(obs_drop[2]), 32'd21);
        chk({name, " drop3"}, 32'(obs_drop[3]), 32'd26);
        chk({name, " done"},  32'(obs_done),    32'd30);
    endtask

    initial begin
        // Nominal release with every ack immediately available.
        set_dly(0, 0, 0, 0);
        begin_scn("t1", 1'b0);
        play("t1", scen_end);
        chk_pitch("t1");

        // Software restart from DONE replays the identical timing.
        begin_scn("t4", 1'b1);
        play("t4", scen_end);
        chk_pitch("t4");

        // Late ack on stage 2.
        set_dly(0, 0, 7, 0);
        begin_scn("t2", 1'b0);
        play("t2", scen_end);
        chk("t2 drop3", 32'(obs_drop[3]), 32'd33);

        // Stage 1 never acks: one retry, then lock; sw restart out of the lock.
        set_dly(0, 30, 0, 0);
        begin_scn("t3", 1'b0);
        play("t3", scen_end);
        set_dly(0, 0, 0, 0);
        begin_scn("t3sw", 1'b1);
        play("t3sw", scen_end);

        // sw request lands on the same edge as the timeout expiry (edge 36).
        set_dly(0, 30, 0, 0);
        begin_scn("t5", 1'b0);
        play("t5", 35);
        set_dly(0, 0, 0, 0);
        begin_scn("t5sw", 1'b1);
        play("t5sw", scen_end);

        // rst mid-GAP with stages 0 and 1 released.
        set_dly(0, 0, 0, 0);
        begin_scn("t6", 1'b0);
        play("t6", 18);
        chk("t6 pre-rst stages", 32'(rst_stage_o), 32'h0000_000C);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t6 rst edge stages", 32'(rst_stage_o), 32'h0000_000F);
        begin_scn("t6r", 1'b0);
        play("t6r", scen_end);

        // Randomised ack delays, occasionally beyond the timeout.
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 4; k++)
                dly[k] = ($urandom_range(0, 9) == 0) ? 30 : int'($urandom_range(0, 12));
            begin_scn($sformatf("rnd%0d", i), ($urandom_range(0, 1) == 1));
            play($sformatf("rnd%0d", i), scen_end);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
